// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: state encoding, reset snapshot
// and the channel-to-select mapping of the downstream 4:1 mux.
package mux_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSelect = 2'd1,
        StEnable = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam logic [3:0] SnapReset = 4'b1111;

    // The mux decodes its channel as {C[0],C[1]}, so the bits are swapped on the way out.
    function automatic logic [1:0] ch_to_c(input logic [1:0] ch);
        return {ch[0], ch[1]};
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Control/data bundle between the scan sequencer (slave) and its environment (master).
interface mux_scan_ctrl_if;
    logic       start;
    logic       abort;
    logic [3:0] ch_mask;
    logic       mux_g;
    logic [1:0] mux_c;
    logic       mux_y;
    logic [3:0] data;
    logic       busy;
    logic       done;

    modport slave (
        input  start, abort, ch_mask, mux_y,
        output mux_g, mux_c, data, busy, done
    );

    modport master (
        output start, abort, ch_mask, mux_y,
        input  mux_g, mux_c, data, busy, done
    );
endinterface

// File: rtl/mux_scan_next.sv
// Priority finder: lowest set mask bit above the current channel, or from
// channel 0 inclusive when from_zero is set.
module mux_scan_next (
    input  logic [3:0] mask,
    input  logic [1:0] cur,
    input  logic       from_zero,
    output logic [1:0] nxt,
    output logic       none
);
    always_comb begin
        nxt  = 2'd0;
        none = 1'b1;
        // Descending walk so the lowest qualifying channel is the one left standing.
        for (int k = 3; k >= 0; k--) begin
            if (mask[k] && (from_zero || (k > int'(cur)))) begin
                nxt  = 2'(k);
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 active-low-enable mux: break-before-make select,
// settle, sample, and atomic commit of a 4-bit snapshot.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input logic                  clk,
    input logic                  rst,
    mux_scan_ctrl_if.slave       bus
);

    state_e     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] data_q, data_d;
    logic       g_q, g_d;
    logic [1:0] c_q, c_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] find_mask;
    logic       find_from_zero;
    logic [1:0] find_nxt;
    logic       find_none;

    localparam logic [3:0] CntLast = 4'(SETTLE_CYC - 1);

    mux_scan_next u_next (
        .mask      (find_mask),
        .cur       (ch_q),
        .from_zero (find_from_zero),
        .nxt       (find_nxt),
        .none      (find_none)
    );

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        cnt_d          = cnt_q;
        mask_d         = mask_q;
        shadow_d       = shadow_q;
        data_d         = data_q;
        find_mask      = mask_q;
        find_from_zero = 1'b0;

        unique case (state_q)
            StIdle: begin
                find_mask      = bus.ch_mask;
                find_from_zero = 1'b1;
                if (bus.start) begin
                    mask_d   = bus.ch_mask;
                    shadow_d = SnapReset;
                    cnt_d    = 4'd0;
                    if (find_none) begin
                        state_d = StDone;
                    end else begin
                        state_d = StSelect;
                        ch_d    = find_nxt;
                    end
                end
            end
            StSelect: begin
                cnt_d   = 4'd0;
                state_d = bus.abort ? StIdle : StEnable;
            end
            StEnable: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    shadow_d[ch_q] = bus.mux_y;
                    if (find_none) begin
                        state_d = StDone;
                    end else begin
                        state_d = StSelect;
                        ch_d    = find_nxt;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StDone) begin
            data_d = shadow_d;
        end

        // Outputs are decoded from the next state so every port comes straight from a flop.
        g_d    = (state_d != StEnable);
        c_d    = ((state_d == StSelect) || (state_d == StEnable)) ? ch_to_c(ch_d) : 2'b00;
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ch_q     <= 2'd0;
            cnt_q    <= 4'd0;
            mask_q   <= 4'd0;
            shadow_q <= SnapReset;
            data_q   <= SnapReset;
            g_q      <= 1'b1;
            c_q      <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            g_q      <= g_d;
            c_q      <= c_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.mux_g = g_q;
    assign bus.mux_c = c_q;
    assign bus.data  = data_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
